// File: rtl/nios_fprint_sp_pkg.sv
// Shared defaults and port identifiers for the fingerprint scratchpad arbiter.
package nios_fprint_sp_pkg;

  localparam int SP_ADDR_W   = 12;
  localparam int SP_DATA_W   = 32;
  localparam int SP_MAX_HOLD = 4;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_e;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_CPU) ? PORT_DMA : PORT_CPU;
  endfunction

  function automatic logic [1:0] port_onehot(input port_e p);
    return (p == PORT_DMA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/nios_fprint_rr_grant2.sv
// Two-way round-robin grant with a bounded hold window; owns the last/hold_cnt state.
module nios_fprint_rr_grant2
  import nios_fprint_sp_pkg::*;
#(
  parameter int MAX_HOLD = SP_MAX_HOLD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  localparam int            HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  port_e         last;
  logic [HW-1:0] hold_cnt;
  port_e         winner;

  // hold_cnt == 0 only before the first accepted transfer: no owner yet, CPU wins.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (hold_cnt == '0)          grant = port_onehot(PORT_CPU);
        else if (hold_cnt < HOLD_MAX) grant = port_onehot(last);
        else                          grant = port_onehot(other_port(last));
      end
      default: grant = 2'b00;
    endcase
  end

  assign winner = grant[1] ? PORT_DMA : PORT_CPU;

  always_ff @(posedge clk) begin
    if (reset) begin
      last     <= PORT_DMA;
      hold_cnt <= '0;
    end else if (accept) begin
      if (winner == last) begin
        if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
      end else begin
        last     <= winner;
        hold_cnt <= HW'(1);
      end
    end
  end

endmodule

// File: rtl/nios_fprint_scratchpad_arbiter.sv
// Shares one single-port scratchpad between CPU (port 0) and DMA (port 1) masters,
// steering the one-cycle read return back to the issuing port.
module nios_fprint_scratchpad_arbiter
  import nios_fprint_sp_pkg::*;
#(
  parameter int ADDR_W   = SP_ADDR_W,
  parameter int DATA_W   = SP_DATA_W,
  parameter int MAX_HOLD = SP_MAX_HOLD
) (
  input  logic                clk,
  input  logic                reset,

  input  logic [ADDR_W-1:0]   p0_address,
  input  logic [DATA_W/8-1:0] p0_byteenable,
  input  logic                p0_read,
  input  logic                p0_write,
  input  logic [DATA_W-1:0]   p0_writedata,
  output logic                p0_waitrequest,
  output logic [DATA_W-1:0]   p0_readdata,
  output logic                p0_readdatavalid,

  input  logic [ADDR_W-1:0]   p1_address,
  input  logic [DATA_W/8-1:0] p1_byteenable,
  input  logic                p1_read,
  input  logic                p1_write,
  input  logic [DATA_W-1:0]   p1_writedata,
  output logic                p1_waitrequest,
  output logic [DATA_W-1:0]   p1_readdata,
  output logic                p1_readdatavalid,

  output logic [ADDR_W-1:0]   sp_address,
  output logic [DATA_W/8-1:0] sp_byteenable,
  output logic                sp_chipselect,
  output logic                sp_write,
  output logic [DATA_W-1:0]   sp_writedata,
  output logic                sp_clken,
  input  logic [DATA_W-1:0]   sp_readdata
);

  localparam int BE_W   = DATA_W / 8;
  localparam int STAGES = 1;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
  } av_req_t;

  av_req_t [1:0]   rq;
  av_req_t         sel_rq;
  logic [1:0]      req;
  logic [1:0]      grant;
  logic            rd_issue;
  logic            vld_q;
  logic [STAGES:0] vld_pipe;
  port_e           rd_port;

  assign rq[0] = {p0_address, p0_byteenable, p0_read, p0_write, p0_writedata};
  assign rq[1] = {p1_address, p1_byteenable, p1_read, p1_write, p1_writedata};

  // No grant is issued while reset is high, so waitrequest simply mirrors req.
  assign req = {rq[1].read | rq[1].write, rq[0].read | rq[0].write} & {2{~reset}};

  nios_fprint_rr_grant2 #(
    .MAX_HOLD (MAX_HOLD)
  ) u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .accept (|grant),
    .grant  (grant)
  );

  assign p0_waitrequest = (p0_read | p0_write) & ~grant[0];
  assign p1_waitrequest = (p1_read | p1_write) & ~grant[1];

  assign sel_rq        = grant[1] ? rq[1] : rq[0];
  assign sp_address    = sel_rq.address;
  assign sp_byteenable = sel_rq.byteenable;
  assign sp_writedata  = sel_rq.writedata;
  assign sp_chipselect = |grant;
  assign sp_write      = (|grant) & sel_rq.write;
  assign sp_clken      = ~reset;

  // Read+write together is handled as a write, so it never returns data.
  assign rd_issue = (|grant) & sel_rq.read & ~sel_rq.write;
  assign vld_pipe = {vld_q, rd_issue};

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= 1'b0;
      rd_port <= PORT_CPU;
    end else begin
      vld_q   <= vld_pipe[STAGES-1];
      rd_port <= grant[1] ? PORT_DMA : PORT_CPU;
    end
  end

  assign p0_readdata      = sp_readdata;
  assign p1_readdata      = sp_readdata;
  assign p0_readdatavalid = vld_pipe[STAGES] & (rd_port == PORT_CPU) & ~reset;
  assign p1_readdatavalid = vld_pipe[STAGES] & (rd_port == PORT_DMA) & ~reset;

endmodule

// File: tb/tb_nios_fprint_scratchpad_arbiter.sv
// Directed bench for the scratchpad arbiter with a behavioural 4096x32 byte-enabled RAM.
module tb_nios_fprint_scratchpad_arbiter;

  logic        clk;
  logic        reset;
  logic [11:0] p0_address, p1_address;
  logic [3:0]  p0_byteenable, p1_byteenable;
  logic        p0_read, p0_write, p1_read, p1_write;
  logic [31:0] p0_writedata, p1_writedata;
  logic        p0_waitrequest, p1_waitrequest;
  logic [31:0] p0_readdata, p1_readdata;
  logic        p0_readdatavalid, p1_readdatavalid;
  logic [11:0] sp_address;
  logic [3:0]  sp_byteenable;
  logic        sp_chipselect, sp_write, sp_clken;
  logic [31:0] sp_writedata;
  logic [31:0] sp_readdata;

  int passed = 0;
  int total  = 0;

  nios_fprint_scratchpad_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .p0_address       (p0_address),
    .p0_byteenable    (p0_byteenable),
    .p0_read          (p0_read),
    .p0_write         (p0_write),
    .p0_writedata     (p0_writedata),
    .p0_waitrequest   (p0_waitrequest),
    .p0_readdata      (p0_readdata),
    .p0_readdatavalid (p0_readdatavalid),
    .p1_address       (p1_address),
    .p1_byteenable    (p1_byteenable),
    .p1_read          (p1_read),
    .p1_write         (p1_write),
    .p1_writedata     (p1_writedata),
    .p1_waitrequest   (p1_waitrequest),
    .p1_readdata      (p1_readdata),
    .p1_readdatavalid (p1_readdatavalid),
    .sp_address       (sp_address),
    .sp_byteenable    (sp_byteenable),
    .sp_chipselect    (sp_chipselect),
    .sp_write         (sp_write),
    .sp_writedata     (sp_writedata),
    .sp_clken         (sp_clken),
    .sp_readdata      (sp_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scratchpad model: contents reload to C0DE0000|addr during reset.
  logic [31:0] mem [4096];
  logic [31:0] ram_w;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'hC0DE_0000 | i;
    end else if (sp_clken && sp_chipselect) begin
      if (sp_write) begin
        ram_w = mem[sp_address];
        for (int b = 0; b < 4; b++)
          if (sp_byteenable[b]) ram_w[8*b +: 8] = sp_writedata[8*b +: 8];
        mem[sp_address] <= ram_w;
      end else begin
        sp_readdata <= mem[sp_address];
      end
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(p0_read && p0_write)) else $error("port 0 read and write asserted together");
      assert (!(p1_read && p1_write)) else $error("port 1 read and write asserted together");
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p0_read = 0; p0_write = 0; p1_read = 0; p1_write = 0;
    p0_address = '0; p1_address = '0;
    p0_byteenable = 4'hF; p1_byteenable = 4'hF;
    p0_writedata = '0; p1_writedata = '0;
  endtask

  task automatic apply_reset(input int n);
    idle_inputs();
    reset = 1;
    repeat (n) tick();
    reset = 0;
  endtask

  task automatic test_reset();
    tick(); tick();
    p0_read = 1; p1_read = 1;
    #1;
    total++; if (p0_waitrequest !== 1'b1) $display("FAIL reset_p0_wait: got %b want 1", p0_waitrequest); else passed++;
    total++; if (p1_waitrequest !== 1'b1) $display("FAIL reset_p1_wait: got %b want 1", p1_waitrequest); else passed++;
    total++; if (sp_chipselect !== 1'b0) $display("FAIL reset_cs: got %b want 0", sp_chipselect); else passed++;
    total++; if (sp_clken !== 1'b0) $display("FAIL reset_clken: got %b want 0", sp_clken); else passed++;
    tick();
    total++; if ({p0_readdatavalid, p1_readdatavalid} !== 2'b00) $display("FAIL reset_rdv: got %b want 00", {p0_readdatavalid, p1_readdatavalid}); else passed++;
    idle_inputs();
    reset = 0;
    #1;
    total++; if (sp_clken !== 1'b1) $display("FAIL release_clken: got %b want 1", sp_clken); else passed++;
    total++; if ({p0_waitrequest, p1_waitrequest} !== 2'b00) $display("FAIL idle_wait: got %b want 00", {p0_waitrequest, p1_waitrequest}); else passed++;
    tick();
  endtask

  task automatic test_single_p0();
    p0_write = 1; p0_address = 12'h010; p0_byteenable = 4'hF; p0_writedata = 32'hDEADBEEF;
    #1;
    total++; if (p0_waitrequest !== 1'b0) $display("FAIL sp0_wr_wait: got %b want 0", p0_waitrequest); else passed++;
    total++; if ({sp_chipselect, sp_write} !== 2'b11) $display("FAIL sp0_wr_ctl: got %b want 11", {sp_chipselect, sp_write}); else passed++;
    total++; if (sp_address !== 12'h010) $display("FAIL sp0_wr_addr: got %h want 010", sp_address); else passed++;
    total++; if (sp_writedata !== 32'hDEADBEEF) $display("FAIL sp0_wr_data: got %h want deadbeef", sp_writedata); else passed++;
    tick();
    p0_write = 0; p0_read = 1;
    #1;
    total++; if (p0_waitrequest !== 1'b0) $display("FAIL sp0_rd_wait: got %b want 0", p0_waitrequest); else passed++;
    total++; if (sp_write !== 1'b0) $display("FAIL sp0_rd_spwrite: got %b want 0", sp_write); else passed++;
    total++; if (p0_readdatavalid !== 1'b0) $display("FAIL sp0_wr_no_rdv: got %b want 0", p0_readdatavalid); else passed++;
    tick();
    p0_read = 0;
    #1;
    total++; if (p0_readdatavalid !== 1'b1) $display("FAIL sp0_rdv: got %b want 1", p0_readdatavalid); else passed++;
    total++; if (p0_readdata !== 32'hDEADBEEF) $display("FAIL sp0_rdata: got %h want deadbeef", p0_readdata); else passed++;
    total++; if (p1_readdatavalid !== 1'b0) $display("FAIL sp0_p1_rdv: got %b want 0", p1_readdatavalid); else passed++;
    tick();
  endtask

  task automatic test_byte_lane();
    p1_write = 1; p1_address = 12'h010; p1_byteenable = 4'h1; p1_writedata = 32'h000000AA;
    #1;
    total++; if (p1_waitrequest !== 1'b0) $display("FAIL bl_wait: got %b want 0", p1_waitrequest); else passed++;
    total++; if (sp_byteenable !== 4'h1) $display("FAIL bl_be: got %h want 1", sp_byteenable); else passed++;
    tick();
    p1_write = 0; p1_read = 1; p1_byteenable = 4'hF;
    tick();
    p1_read = 0;
    #1;
    total++; if (p1_readdatavalid !== 1'b1) $display("FAIL bl_rdv: got %b want 1", p1_readdatavalid); else passed++;
    total++; if (p1_readdata !== 32'hDEADBEAA) $display("FAIL bl_rdata: got %h want deadbeaa", p1_readdata); else passed++;
    total++; if (p0_readdatavalid !== 1'b0) $display("FAIL bl_p0_rdv: got %b want 0", p0_readdatavalid); else passed++;
    tick();
  endtask

  task automatic test_first_contention();
    apply_reset(2);
    p0_read = 1; p1_read = 1; p0_address = 12'h000; p1_address = 12'h000;
    #1;
    total++; if ({p1_waitrequest, p0_waitrequest} !== 2'b10) $display("FAIL fc_wait0: got %b want 10", {p1_waitrequest, p0_waitrequest}); else passed++;
    tick();
    p0_read = 0;
    #1;
    total++; if (p1_waitrequest !== 1'b0) $display("FAIL fc_wait1: got %b want 0", p1_waitrequest); else passed++;
    total++; if ({p1_readdatavalid, p0_readdatavalid} !== 2'b01) $display("FAIL fc_rdv0: got %b want 01", {p1_readdatavalid, p0_readdatavalid}); else passed++;
    total++; if (p0_readdata !== 32'hC0DE0000) $display("FAIL fc_rdata0: got %h want c0de0000", p0_readdata); else passed++;
    tick();
    p1_read = 0;
    #1;
    total++; if ({p1_readdatavalid, p0_readdatavalid} !== 2'b10) $display("FAIL fc_rdv1: got %b want 10", {p1_readdatavalid, p0_readdatavalid}); else passed++;
    total++; if (p1_readdata !== 32'hC0DE0000) $display("FAIL fc_rdata1: got %h want c0de0000", p1_readdata); else passed++;
    tick();
  endtask

  task automatic test_contention();
    logic        exp1, prev1;
    logic [31:0] prev_data;
    int n0, n1, w0, w1, mw0, mw1;
    n0 = 0; n1 = 0; w0 = 0; w1 = 0; mw0 = 0; mw1 = 0;
    prev1 = 0; prev_data = '0;
    apply_reset(2);
    p0_read = 1; p1_read = 1;
    for (int c = 0; c < 16; c++) begin
      exp1 = ((c / 4) % 2) == 1;
      p0_address = 12'h100 + 12'(n0);
      p1_address = 12'h200 + 12'(n1);
      #1;
      total++; if ({p1_waitrequest, p0_waitrequest} !== {~exp1, exp1})
        $display("FAIL cont_grant c=%0d: got wait %b want %b", c, {p1_waitrequest, p0_waitrequest}, {~exp1, exp1}); else passed++;
      if (c > 0) begin
        total++; if ({p1_readdatavalid, p0_readdatavalid} !== {prev1, ~prev1} || p0_readdata !== prev_data)
          $display("FAIL cont_return c=%0d: got rdv %b data %h want rdv %b data %h", c,
                   {p1_readdatavalid, p0_readdatavalid}, p0_readdata, {prev1, ~prev1}, prev_data); else passed++;
      end
      w0 = p0_waitrequest ? w0 + 1 : 0;
      w1 = p1_waitrequest ? w1 + 1 : 0;
      if (w0 > mw0) mw0 = w0;
      if (w1 > mw1) mw1 = w1;
      prev1     = exp1;
      prev_data = exp1 ? (32'hC0DE0200 + n1) : (32'hC0DE0100 + n0);
      if (exp1) n1++; else n0++;
      tick();
    end
    p0_read = 0; p1_read = 0;
    #1;
    total++; if ({p1_readdatavalid, p0_readdatavalid} !== {prev1, ~prev1} || p1_readdata !== prev_data)
      $display("FAIL cont_last_return: got rdv %b data %h want rdv %b data %h",
               {p1_readdatavalid, p0_readdatavalid}, p1_readdata, {prev1, ~prev1}, prev_data); else passed++;
    total++; if (mw0 > 4 || mw1 > 4) $display("FAIL cont_max_wait: got %0d/%0d want <=4", mw0, mw1); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_read();
    apply_reset(2);
    p1_read = 1; p1_address = 12'h020;
    #1;
    total++; if (p1_waitrequest !== 1'b0) $display("FAIL rmr_wait: got %b want 0", p1_waitrequest); else passed++;
    tick();
    p1_read = 0; reset = 1;
    #1;
    total++; if (p1_readdatavalid !== 1'b0) $display("FAIL rmr_rdv_in_reset: got %b want 0", p1_readdatavalid); else passed++;
    tick();
    reset = 0;
    #1;
    total++; if (p1_readdatavalid !== 1'b0) $display("FAIL rmr_rdv_after: got %b want 0", p1_readdatavalid); else passed++;
    p0_read = 1; p1_read = 1; p0_address = 12'h030; p1_address = 12'h040;
    #1;
    total++; if ({p1_waitrequest, p0_waitrequest} !== 2'b10) $display("FAIL rmr_first_grant: got %b want 10", {p1_waitrequest, p0_waitrequest}); else passed++;
    tick();
    p0_read = 0;
    #1;
    total++; if (p0_readdatavalid !== 1'b1 || p0_readdata !== 32'hC0DE0030) $display("FAIL rmr_p0_return: got %b %h want 1 c0de0030", p0_readdatavalid, p0_readdata); else passed++;
    tick();
    p1_read = 0;
    #1;
    total++; if (p1_readdatavalid !== 1'b1 || p1_readdata !== 32'hC0DE0040) $display("FAIL rmr_p1_return: got %b %h want 1 c0de0040", p1_readdatavalid, p1_readdata); else passed++;
    tick();
  endtask

  task automatic test_idle();
    logic exp1;
    apply_reset(2);
    p1_read = 1; p1_address = 12'h050;
    tick();
    p1_address = 12'h051;
    tick();
    p1_read = 0;
    p0_address = 12'h3AB; p1_address = 12'h155; p0_byteenable = 4'h3; p1_byteenable = 4'hC;
    #1;
    total++; if (p1_readdatavalid !== 1'b1 || p1_readdata !== 32'hC0DE0051) $display("FAIL idle_pre_return: got %b %h want 1 c0de0051", p1_readdatavalid, p1_readdata); else passed++;
    for (int c = 0; c < 10; c++) begin
      total++; if ({sp_chipselect, sp_write} !== 2'b00) $display("FAIL idle_ctl c=%0d: got %b want 00", c, {sp_chipselect, sp_write}); else passed++;
      total++; if (sp_address !== 12'h3AB || sp_byteenable !== 4'h3) $display("FAIL idle_bus c=%0d: got %h %h want 3ab 3", c, sp_address, sp_byteenable); else passed++;
      if (c > 0) begin
        total++; if ({p1_readdatavalid, p0_readdatavalid} !== 2'b00) $display("FAIL idle_rdv c=%0d: got %b want 00", c, {p1_readdatavalid, p0_readdatavalid}); else passed++;
      end
      tick();
    end
    // State left as DMA owner with two grants: it keeps two more, then CPU.
    p0_read = 1; p1_read = 1; p0_byteenable = 4'hF; p1_byteenable = 4'hF;
    for (int c = 0; c < 3; c++) begin
      exp1 = (c < 2);
      #1;
      total++; if ({p1_waitrequest, p0_waitrequest} !== {~exp1, exp1})
        $display("FAIL idle_resume c=%0d: got wait %b want %b", c, {p1_waitrequest, p0_waitrequest}, {~exp1, exp1}); else passed++;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_single_p0();
    test_byte_lane();
    test_first_contention();
    test_contention();
    test_reset_mid_read();
    test_idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nios_fprint_scratchpad_arbiter.md
# nios_fprint_scratchpad_arbiter

Two-port arbiter that shares one single-port processor scratchpad (4096 x 32, byte-enabled, one-cycle read latency) between the processor data master (port 0) and the fingerprint/DMA master (port 1). It accepts at most one Avalon-MM transfer per cycle onto the RAM. Arbitration is round-robin with a bounded hold window. The block returns pipelined read data with `readdatavalid` to the port that issued the read.

## Interface
Parameters:
- `ADDR_W`, default 12: word-address width of the scratchpad.
- `DATA_W`, default 32: data width; byteenable width is `DATA_W/8`.
- `MAX_HOLD`, default 4: maximum consecutive grants to one port while the other port is requesting.

Ports (`p` = 0 or 1):
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high reset.
- `p<p>_address` in `ADDR_W`: word address.
- `p<p>_byteenable` in 4: byte lanes.
- `p<p>_read` in 1: read request.
- `p<p>_write` in 1: write request.
- `p<p>_writedata` in 32: write data.
- `p<p>_waitrequest` out 1: transfer not accepted this cycle.
- `p<p>_readdata` out 32: read data.
- `p<p>_readdatavalid` out 1: `readdata` valid.
- `sp_address` out `ADDR_W`: scratchpad address.
- `sp_byteenable` out 4: scratchpad byte lanes.
- `sp_chipselect` out 1: scratchpad chipselect.
- `sp_write` out 1: scratchpad write.
- `sp_writedata` out 32: scratchpad write data.
- `sp_clken` out 1: scratchpad clock enable.
- `sp_readdata` in 32: scratchpad `q`, valid the cycle after the address is presented.

## Operation
- Request per port: `req_p = p_read | p_write`. Asserting read and write together on one port is illegal; the bench flags it with an assertion. The RTL treats that case as a write.
- Grant is combinational from `req0`, `req1`, the `last` register and the `hold_cnt` register:
  - Only one port requesting: that port is granted.
  - Both requesting, `hold_cnt < MAX_HOLD`: the port in `last` keeps the grant.
  - Both requesting, `hold_cnt == MAX_HOLD`: the other port is granted.
  - Both requesting with no prior owner after reset: port 0 is granted.
- `p<p>_waitrequest = req_p & ~grant_p`. An idle port sees `waitrequest = 0`.
- Scratchpad drive:
  - Granted port's address, byteenable and writedata are muxed onto the `sp_*` outputs.
  - `sp_chipselect` = any grant.
  - `sp_write` = granted port's write.
  - With no grant, `sp_chipselect = 0`, `sp_write = 0` and the `sp_*` data buses hold port 0's values.
- Hold counter update on each accepted transfer:
  - Same port as `last`: `hold_cnt` increments, saturating at `MAX_HOLD`.
  - Different port: `hold_cnt` becomes 1 and `last` becomes that port.
  - When `req` from the non-`last` port is low, `hold_cnt` saturates and does not force a switch.
  - With no grant, `hold_cnt` and `last` are unchanged.
- Read return pipeline:
  - A 1-stage register captures `rd_pend` (granted and read) and `rd_port`.
  - The cycle after an accepted read, `p<rd_port>_readdatavalid = 1`. The other port's `readdatavalid` stays 0.
  - `p0_readdata` and `p1_readdata` are both driven directly from `sp_readdata`; only `readdatavalid` is steered.
- `sp_clken = ~reset`.

## Timing
- Reset values:
  - All `readdatavalid` = 0.
  - `rd_pend` = 0.
  - `hold_cnt` = 0.
  - `last` = 1, so port 0 wins the first contention.
  - `sp_clken` = 0 while `reset` is high.
  - `waitrequest` is combinational: during reset, `waitrequest = req` on both ports, and no grant is issued.
- Latency:
  - Transfer accepted in the same cycle it is presented when granted.
  - Read data and `readdatavalid` appear exactly 1 cycle after acceptance.
  - Writes complete on acceptance.
- Throughput: one transfer per cycle sustained; back-to-back reads from alternating ports each return in order, 1 cycle later.
- Contention fairness: under continuous contention the grant pattern is `MAX_HOLD` grants to one port, then `MAX_HOLD` to the other. Worst-case wait for a requester is `MAX_HOLD` cycles.
- Avalon rule: a master holds its request stable while `waitrequest = 1`. The arbiter never deasserts `waitrequest` for a port it does not grant in that cycle.
- Reset mid-operation: a read accepted the cycle before reset asserts produces no `readdatavalid`. The pending read is dropped.

## Structure
- Package `nios_fprint_sp_pkg`: `ADDR_W` and `DATA_W` defaults, and a port-index enum (`PORT_CPU = 0`, `PORT_DMA = 1`).
- One sub-module, `nios_fprint_rr_grant2`: 2-way round-robin grant with hold counter. Inputs `req[1:0]` and `accept`; outputs `grant[1:0]`. It contains the `last` and `hold_cnt` registers.
- Top level holds the mux and the read-return pipeline register.

## Test plan
- Single port 0: write 0xDEADBEEF to address 0x010 with byteenable 0xF, then read 0x010 → `waitrequest` 0 on both cycles; `p0_readdatavalid` asserted 1 cycle after the read with `readdata` 0xDEADBEEF.
- Byte-lane write: port 1 writes 0x000000AA with byteenable 0x1 to address 0x010 (holding 0xDEADBEEF), then reads 0x010 → returns 0xDEADBEAA.
- Simultaneous first request after reset: both ports read address 0x000 → port 0 granted; `p1_waitrequest` 1 for that cycle; port 1 granted the next cycle; `readdatavalid` appears on p0, then on p1, in consecutive cycles.
- Continuous contention, `MAX_HOLD = 4`: both ports issue back-to-back reads for 16 cycles → grant pattern 0000 1111 0000 1111; no port ever waits more than 4 cycles.
- Reset mid-read: port 1 read accepted in cycle N, `reset` high in cycle N+1 → `p1_readdatavalid` stays 0; after reset release, the first contention goes to port 0.
- Idle behaviour: no requests for 10 cycles → `sp_chipselect` 0, `sp_write` 0, all `readdatavalid` 0, `hold_cnt` and `last` unchanged.
